// File: rtl/enc_pkg.sv
// Shared types and sizing for the SECDED encoder pipeline.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package enc_pkg;

    // Codeword size selector; the encoding matches the CODEWORD_WIDTH input pins.
    typedef enum logic [1:0] {
        CW8        = 2'b00,
        CW16       = 2'b01,
        CW32       = 2'b10,
        CW_ILLEGAL = 2'b11
    } cw_mode_e;

    // Data bits (K) and codeword bits (N) for each legal mode.
    localparam int K_CW8  = 4;
    localparam int N_CW8  = 8;
    localparam int K_CW16 = 11;
    localparam int N_CW16 = 16;
    localparam int K_CW32 = 26;
    localparam int N_CW32 = 32;

    // Codeword length for a mode; 0 for the illegal mode, so no position is ever populated.
    function automatic int cw_len(input cw_mode_e mode);
        case (mode)
            CW8:     return N_CW8;
            CW16:    return N_CW16;
            CW32:    return N_CW32;
            default: return 0;
        endcase
    endfunction

    // Number of payload bits carried by a mode; 0 for the illegal mode.
    function automatic int data_len(input cw_mode_e mode);
        case (mode)
            CW8:     return K_CW8;
            CW16:    return K_CW16;
            CW32:    return K_CW32;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/hamming_parity_calc.sv
// Combinational extended-Hamming encoder: {mode,data} -> {codeword,err}.
// Latency: 0 cycles (pure logic, sits in front of the second pipeline register).
// Backpressure: none; output follows inputs.
module hamming_parity_calc
    import enc_pkg::*;
#(
    parameter int MAX_CW = 32,
    parameter int DATA_W = 33
) (
    input  cw_mode_e            mode,
    input  logic [DATA_W-1:0]   data,
    output logic [MAX_CW-1:0]   codeword,
    output logic                err
);

    localparam int IW = $clog2(MAX_CW);
    localparam int DW = $clog2(DATA_W + 1);

    logic [MAX_CW-1:0] placed;
    logic [DW-1:0]     di;
    logic [IW-1:0]     par;
    int                n;

    // Scatter data bits, ascending, into every non-power-of-two position below N.
    always_comb begin
        n      = cw_len(mode);
        placed = '0;
        di     = '0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if ((pos < n) && ((pos & (pos - 1)) != 0)) begin
                placed[IW'(pos)] = data[di];
                di               = di + DW'(1);
            end
        end
    end

    // Parity bit k covers every populated position whose index has bit k set.
    always_comb begin
        par = '0;
        for (int k = 0; k < IW; k++) begin
            for (int pos = 1; pos < MAX_CW; pos++) begin
                if ((pos < n) && pos[k]) begin
                    par[k] = par[k] ^ placed[IW'(pos)];
                end
            end
        end
    end

    // Merge parity into its power-of-two slots, add overall parity at bit 0, squash illegal words.
    always_comb begin
        codeword = placed;
        err      = 1'b0;
        for (int k = 0; k < IW; k++) begin
            if ((1 << k) < n) begin
                codeword[IW'(1 << k)] = par[k];
            end
        end
        codeword[0] = ^codeword[MAX_CW-1:1];
        if (mode == CW_ILLEGAL) begin
            codeword = '0;
            err      = 1'b1;
        end
    end

endmodule

// File: rtl/secded_encoder_pipe.sv
// Two-stage pipelined SECDED encoder with per-word mode, error flagging and a legal-word counter.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: valid/ready; in_ready is combinational from out_ready, output held stable while stalled.
module secded_encoder_pipe
    import enc_pkg::*;
#(
    parameter int MAX_CW = 32,
    parameter int DATA_W = 33,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          CODEWORD_WIDTH,
    input  logic [DATA_W-1:0]   data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MAX_CW-1:0]   data_out,
    output logic                out_err,
    output logic                err_sticky,
    input  logic                clr_err,
    output logic [CNT_W-1:0]    enc_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1: raw word as received
    logic              s1_valid_q, s1_valid_d;
    cw_mode_e          s1_mode_q,  s1_mode_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;

    // Stage 2: encoded codeword
    logic              s2_valid_q, s2_valid_d;
    logic [MAX_CW-1:0] s2_cw_q,    s2_cw_d;
    logic              s2_err_q,   s2_err_d;

    // Status
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              sticky_q,   sticky_d;

    logic              s1_adv;
    logic              s2_adv;
    logic              out_xfer;
    logic [MAX_CW-1:0] enc_cw;
    logic              enc_err;

    hamming_parity_calc #(
        .MAX_CW (MAX_CW),
        .DATA_W (DATA_W)
    ) u_calc (
        .mode     (s1_mode_q),
        .data     (s1_data_q),
        .codeword (enc_cw),
        .err      (enc_err)
    );

    // Advance conditions: a stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        in_ready = s1_adv;
        out_xfer = s2_valid_q & out_ready;
    end

    // Stage 1 next state: capture mode and data with each accepted word so modes can change freely.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = cw_mode_e'(CODEWORD_WIDTH);
                s1_data_d = data_in;
            end
        end
    end

    // Stage 2 next state: register the encoder output when stage 1 hands over a word.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_cw_d    = s2_cw_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_cw_d  = enc_cw;
                s2_err_d = enc_err;
            end
        end
    end

    // Saturating count of legal codewords leaving; sticky error where a new error beats a clear.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (out_xfer && !s2_err_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr_err) begin
            sticky_d = 1'b0;
        end
        if (out_xfer && s2_err_q) begin
            sticky_d = 1'b1;
        end
    end

    // Pipeline and status registers; reset discards any in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= CW8;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_cw_q    <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_cw_q    <= s2_cw_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    // Output view of stage 2 and status.
    always_comb begin
        out_valid  = s2_valid_q;
        data_out   = s2_cw_q;
        out_err    = s2_err_q;
        err_sticky = sticky_q;
        enc_count  = cnt_q;
    end

endmodule

// File: tb/tb_secded_encoder_pipe.sv
// Self-checking bench for secded_encoder_pipe with a queue-based scoreboard.
// Latency: checks 2-cycle latency and 1 word/cycle throughput.
// Backpressure: exercises output stalls, error flagging, saturation and reset.
module tb_secded_encoder_pipe;

    localparam int MAX_CW = 32;
    localparam int DATA_W = 33;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        CODEWORD_WIDTH;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [MAX_CW-1:0] data_out;
    logic              out_err;
    logic              err_sticky;
    logic              clr_err;
    logic [CNT_W-1:0]  enc_count;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] sb_q[$];
    int          out_cyc[$];
    int          cyc    = 0;
    int          exp_cnt = 0;
    int          n_push = 0;
    int          n_pop  = 0;
    logic [31:0] last_out = '0;
    logic [32:0] sb_e;

    secded_encoder_pipe #(
        .MAX_CW (MAX_CW),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .out_err        (out_err),
        .err_sticky     (err_sticky),
        .clr_err        (clr_err),
        .enc_count      (enc_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: place data, then set parity bits to the XOR of indexes of all one bits.
    function automatic logic [32:0] model(input logic [1:0] m, input logic [32:0] d);
        int          n;
        int          j;
        int          syn;
        logic [31:0] cw;
        case (m)
            2'd0:    n = 8;
            2'd1:    n = 16;
            2'd2:    n = 32;
            default: return {1'b1, 32'h0};
        endcase
        cw = '0;
        j  = 0;
        for (int pos = 3; pos < n; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[j];
                j++;
            end
        end
        syn = 0;
        for (int pos = 1; pos < n; pos++) begin
            if (cw[pos]) syn = syn ^ pos;
        end
        for (int b = 0; b < 5; b++) begin
            if ((1 << b) < n) cw[1 << b] = syn[b];
        end
        cw[0] = ^cw[31:1];
        return {1'b0, cw};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("data_out", {32'd0, data_out}, {32'd0, sb_e[31:0]});
                    chk("out_err", {63'd0, out_err}, {63'd0, sb_e[32]});
                    if (!sb_e[32] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
                    last_out = data_out;
                    out_cyc.push_back(cyc);
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(CODEWORD_WIDTH, data_in));
                n_push++;
            end
        end
    end

    task automatic drive(input logic [1:0] m, input logic [32:0] d);
        logic acc;
        acc            = 1'b0;
        CODEWORD_WIDTH = m;
        data_in        = d;
        in_valid       = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        chk("handshake", {63'd0, acc}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", {63'd0, done}, 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        out_cyc.delete();
        exp_cnt = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  cur_m;
        logic [32:0] cur_d;
        logic [31:0] snap;
        int          acc;

        rst_n          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        clr_err        = 1'b0;
        CODEWORD_WIDTH = 2'b00;
        data_in        = '0;
        snap           = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_sticky", {63'd0, err_sticky}, 64'd0);
        chk("rst_count", {60'd0, enc_count}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single words: latency and known codewords
        drive(2'b00, 33'b1011);
        @(negedge clk);
        chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        chk("cw8_1011", {32'd0, data_out}, 64'h0000_00AA);
        drain();
        drive(2'b01, 33'h7FF);
        drain();
        chk("cw16_7ff", {32'd0, last_out}, 64'h0000_FFFF);
        drive(2'b10, 33'h1);
        drain();
        chk("cw32_1", {32'd0, last_out}, 64'h0000_000F);
        chk("count3", {60'd0, enc_count}, 64'd3);

        // Back-to-back, alternating modes
        pulse_reset();
        for (int i = 0; i < 8; i++) drive(2'(i % 3), 33'($urandom));
        drain();
        chk("b2b_outputs", 64'(out_cyc.size()), 64'd8);
        if (out_cyc.size() == 8) chk("b2b_rate", 64'(out_cyc[7] - out_cyc[0]), 64'd7);
        chk("b2b_count", {60'd0, enc_count}, 64'd8);

        // Output stall with continuous input
        out_ready      = 1'b0;
        cur_m          = 2'($urandom_range(0, 2));
        cur_d          = 33'($urandom);
        CODEWORD_WIDTH = cur_m;
        data_in        = cur_d;
        in_valid       = 1'b1;
        acc            = 0;
        for (int c = 0; c < 5; c++) begin
            logic took;
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            if (c == 2) begin
                snap = data_out;
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            end
            if (c > 2) chk("stall_hold", {32'd0, data_out}, {32'd0, snap});
            @(posedge clk);
            #1;
            if (took) begin
                cur_m          = 2'($urandom_range(0, 2));
                cur_d          = 33'($urandom);
                CODEWORD_WIDTH = cur_m;
                data_in        = cur_d;
            end
        end
        chk("stall_accepted", 64'(acc), 64'd2);
        out_ready = 1'b1;
        drive(cur_m, cur_d);
        for (int i = 0; i < 3; i++) drive(2'($urandom_range(0, 2)), 33'($urandom));
        drain();
        chk("no_loss", 64'(n_pop), 64'(n_push));
        chk("stall_count", {60'd0, enc_count}, 64'(exp_cnt));

        // Illegal mode word
        drive(2'b11, 33'h1_2345_6789);
        drain();
        chk("ill_data", {32'd0, last_out}, 64'd0);
        chk("ill_sticky", {63'd0, err_sticky}, 64'd1);
        chk("ill_count", {60'd0, enc_count}, 64'(exp_cnt));
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_sticky", {63'd0, err_sticky}, 64'd0);

        // Set and clear in the same cycle: set wins
        clr_err = 1'b1;
        drive(2'b11, 33'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("set_beats_clr", {63'd0, err_sticky}, 64'd1);
        clr_err = 1'b0;
        drain();
        chk("sticky_held", {63'd0, err_sticky}, 64'd1);

        // Saturation
        pulse_reset();
        chk("post_reset_sticky", {63'd0, err_sticky}, 64'd0);
        for (int i = 0; i < 20; i++) drive(2'($urandom_range(0, 2)), 33'($urandom));
        drain();
        chk("saturate", {60'd0, enc_count}, 64'd15);

        // Reset in the middle of a stream
        CODEWORD_WIDTH = 2'b01;
        data_in        = 33'h155;
        in_valid       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_valid_before", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_count", {60'd0, enc_count}, 64'd0);
        chk("mid_rst_data", {32'd0, data_out}, 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
